// File: rtl/ga_pkg.sv
// Shared types for the GA crossover datapath: chromosome type, crossover FSM states
// and the crossover-point mask helper.
package ga_pkg;

  localparam int CHROM_W = 8;
  localparam int PT_W    = 3;

  typedef logic signed [CHROM_W-1:0] chrom_t;

  typedef enum logic [1:0] {
    COLLECT_A = 2'd0,
    COLLECT_B = 2'd1,
    CROSS     = 2'd2,
    OUTPUT    = 2'd3
  } xo_state_t;

  typedef struct packed {
    chrom_t c1;
    chrom_t c2;
  } child_pair_t;

  // Low-order mask with p ones: bits below the crossover point come from the other parent.
  function automatic chrom_t xo_mask(input logic [PT_W-1:0] p);
    chrom_t m;
    for (int i = 0; i < CHROM_W; i++) begin
      m[i] = (i < int'(p));
    end
    return m;
  endfunction

endpackage

// File: rtl/align_delay.sv
// Fixed-depth shift register with asynchronous active-low clear; used to line the
// chromosome pair and its valid bit up with the registered selection verdict.
module align_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/crossover_unit.sv
// GA crossover stage: collects two tournament winners, performs single-point crossover
// at an RNG-chosen point and offers the two children on a valid/ready output.
// Optional build macro MUTATION_EN adds a 1-in-4 single-bit mutation in CROSS.
module crossover_unit
  import ga_pkg::*;
#(
  parameter int ALIGN_DLY = 2,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [7:0]  chrom1,
  input  logic signed [7:0]  chrom2,
  input  logic               selected,
  input  logic [7:0]         rnd,
  input  logic               child_ready,
  output logic signed [7:0]  child1,
  output logic signed [7:0]  child2,
  output logic               child_valid,
  output logic               busy,
  output logic [CNT_W-1:0]   pair_count,
  output xo_state_t          dbg_state
);

  localparam int LINE_W = 1 + 2 * CHROM_W;

  // Handshake: a child pair transfers on a rising edge where child_valid and child_ready
  // are both high; once raised, child_valid and the children hold until that transfer.

  logic [LINE_W-1:0] line_d;
  logic [LINE_W-1:0] line_q;
  logic              a_valid;
  chrom_t            a_c1;
  chrom_t            a_c2;
  chrom_t            winner;

  assign line_d = {in_valid, chrom1, chrom2};

  align_delay #(
    .DEPTH (ALIGN_DLY),
    .WIDTH (LINE_W)
  ) u_align (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (line_d),
    .q_o   (line_q)
  );

  assign a_valid = line_q[LINE_W-1];
  assign a_c1    = line_q[2*CHROM_W-1:CHROM_W];
  assign a_c2    = line_q[CHROM_W-1:0];
  assign winner  = selected ? a_c1 : a_c2;

  xo_state_t        state_q;
  chrom_t           parent_a_q;
  chrom_t           parent_b_q;
  chrom_t           child1_q;
  chrom_t           child2_q;
  logic             child_valid_q;
  logic             busy_q;
  logic [CNT_W-1:0] pair_count_q;
  child_pair_t      xo_d;
  chrom_t           mask;

  always_comb begin
    mask    = xo_mask(rnd[PT_W-1:0]);
    xo_d.c1 = (parent_a_q & ~mask) | (parent_b_q & mask);
    xo_d.c2 = (parent_b_q & ~mask) | (parent_a_q & mask);
`ifdef MUTATION_EN
    if (rnd[7:6] == 2'b00) begin
      xo_d.c1[rnd[5:3]] = ~xo_d.c1[rnd[5:3]];
      xo_d.c2[rnd[5:3]] = ~xo_d.c2[rnd[5:3]];
    end
`endif
  end

`ifndef MUTATION_EN
  logic unused_rnd;
  assign unused_rnd = ^rnd[7:3];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= COLLECT_A;
      parent_a_q    <= '0;
      parent_b_q    <= '0;
      child1_q      <= '0;
      child2_q      <= '0;
      child_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      pair_count_q  <= '0;
    end else begin
      case (state_q)
        COLLECT_A: begin
          if (a_valid) begin
            parent_a_q <= winner;
            state_q    <= COLLECT_B;
          end
        end
        COLLECT_B: begin
          if (a_valid) begin
            parent_b_q <= winner;
            busy_q     <= 1'b1;
            state_q    <= CROSS;
          end
        end
        CROSS: begin
          child1_q      <= xo_d.c1;
          child2_q      <= xo_d.c2;
          child_valid_q <= 1'b1;
          state_q       <= OUTPUT;
        end
        OUTPUT: begin
          // Aligned winners arriving here are intentionally discarded.
          if (child_ready) begin
            child_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            pair_count_q  <= pair_count_q + 1'b1;
            state_q       <= COLLECT_A;
          end
        end
        default: begin
          state_q <= COLLECT_A;
        end
      endcase
    end
  end

  assign child1      = child1_q;
  assign child2      = child2_q;
  assign child_valid = child_valid_q;
  assign busy        = busy_q;
  assign pair_count  = pair_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_crossover_unit.sv
// Directed bench for crossover_unit: crossover points, stall/drop behaviour,
// asynchronous reset mid-pair and pair-counter wrap (CNT_W = 4).
module tb_crossover_unit;
  import ga_pkg::*;

  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic signed [7:0] chrom1;
  logic signed [7:0] chrom2;
  logic              selected;
  logic [7:0]        rnd;
  logic              child_ready;
  logic signed [7:0] child1;
  logic signed [7:0] child2;
  logic              child_valid;
  logic              busy;
  logic [CNT_W-1:0]  pair_count;
  xo_state_t         dbg_state;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];

  crossover_unit #(
    .ALIGN_DLY (2),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .chrom1      (chrom1),
    .chrom2      (chrom2),
    .selected    (selected),
    .rnd         (rnd),
    .child_ready (child_ready),
    .child1      (child1),
    .child2      (child2),
    .child_valid (child_valid),
    .busy        (busy),
    .pair_count  (pair_count),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one tournament pair; selected follows two cycles later, aligned with the data.
  // Returns at the negedge after the FSM has sampled the aligned winner.
  task automatic send_winner(input logic [7:0] c1, input logic [7:0] c2, input logic sel);
    in_valid = 1'b1;
    chrom1   = c1;
    chrom2   = c2;
    tick();
    in_valid = 1'b0;
    chrom1   = '0;
    chrom2   = '0;
    tick();
    selected = sel;
    tick();
    selected = 1'b0;
  endtask

  // Collect two winners, run CROSS with r, and check the presented children.
  task automatic build_pair(input logic [7:0] a1, input logic [7:0] a2, input logic asel,
                            input logic [7:0] b1, input logic [7:0] b2, input logic bsel,
                            input logic [7:0] r, input logic [7:0] e1, input logic [7:0] e2);
    logic [15:0] e;
    send_winner(a1, a2, asel);
    check("state_collect_b", 32'(dbg_state), 32'(COLLECT_B));
    send_winner(b1, b2, bsel);
    check("state_cross", 32'(dbg_state), 32'(CROSS));
    check("busy_in_cross", 32'(busy), 32'd1);
    check("valid_low_in_cross", 32'(child_valid), 32'd0);
    rnd = r;
    exp_q.push_back({e1, e2});
    tick();
    rnd = 8'h00;
    check("child_valid_rise", 32'(child_valid), 32'd1);
    check("busy_in_output", 32'(busy), 32'd1);
    e = exp_q.pop_front();
    check("child1", 32'($unsigned(child1)), 32'(e[15:8]));
    check("child2", 32'($unsigned(child2)), 32'(e[7:0]));
  endtask

  task automatic handshake(input logic [CNT_W-1:0] exp_cnt);
    child_ready = 1'b1;
    tick();
    child_ready = 1'b0;
    check("valid_drop", 32'(child_valid), 32'd0);
    check("busy_drop", 32'(busy), 32'd0);
    check("state_back_a", 32'(dbg_state), 32'(COLLECT_A));
    check("pair_count", 32'(pair_count), 32'(exp_cnt));
  endtask

  initial begin
    logic [7:0] w1;
    logic [7:0] w2;
    reset       = 1'b0;
    in_valid    = 1'b0;
    chrom1      = '0;
    chrom2      = '0;
    selected    = 1'b0;
    rnd         = 8'h00;
    child_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_child1", 32'($unsigned(child1)), 32'd0);
    check("rst_child2", 32'($unsigned(child2)), 32'd0);
    check("rst_valid", 32'(child_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(pair_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(COLLECT_A));
    reset = 1'b1;
    tick();

    // p = 4 crossover: parents 0x5A / 0xF0
    build_pair(8'h5A, 8'h11, 1'b1, 8'h0F, 8'hF0, 1'b0, 8'h44, 8'h50, 8'hFA);
    handshake(4'd1);

    // p = 0: unchanged copy
    build_pair(8'h5A, 8'h11, 1'b1, 8'h0F, 8'hF0, 1'b0, 8'h40, 8'h5A, 8'hF0);
    handshake(4'd2);

    // rnd = 0x1C: p = 4, mutation selector 00 on bit 3
`ifdef MUTATION_EN
    build_pair(8'h5A, 8'h11, 1'b1, 8'h0F, 8'hF0, 1'b0, 8'h1C, 8'h58, 8'hF2);
`else
    build_pair(8'h5A, 8'h11, 1'b1, 8'h0F, 8'hF0, 1'b0, 8'h1C, 8'h50, 8'hFA);
`endif
    handshake(4'd3);

    // Stall five cycles while winners keep arriving; they must be dropped
    build_pair(8'h5A, 8'h11, 1'b1, 8'h0F, 8'hF0, 1'b0, 8'h44, 8'h50, 8'hFA);
    selected = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      chrom1   = 8'h77;
      chrom2   = 8'h66;
      tick();
      check("stall_valid", 32'(child_valid), 32'd1);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_child1", 32'($unsigned(child1)), 32'h50);
      check("stall_child2", 32'($unsigned(child2)), 32'hFA);
      check("stall_state", 32'(dbg_state), 32'(OUTPUT));
    end
    in_valid = 1'b0;
    chrom1   = '0;
    chrom2   = '0;
    repeat (3) tick();
    selected = 1'b0;
    check("stall_hold_state", 32'(dbg_state), 32'(OUTPUT));
    handshake(4'd4);
    build_pair(8'h21, 8'h99, 1'b1, 8'h44, 8'h33, 1'b0, 8'h40, 8'h21, 8'h33);
    handshake(4'd5);

    // Asynchronous reset while in COLLECT_B
    send_winner(8'h12, 8'h34, 1'b1);
    check("pre_rst_state", 32'(dbg_state), 32'(COLLECT_B));
    #2 reset = 1'b0;
    #1;
    check("async_rst_count", 32'(pair_count), 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'(COLLECT_A));
    check("async_rst_valid", 32'(child_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    build_pair(8'h3C, 8'h00, 1'b1, 8'h00, 8'hC3, 1'b0, 8'h40, 8'h3C, 8'hC3);
    handshake(4'd1);

    // Counter wrap: up to 15, then 16th handshake returns to 0
    for (int i = 2; i <= 16; i++) begin
      w1 = 8'(i * 7);
      w2 = 8'(i * 11 + 3);
      build_pair(w1, 8'hAA, 1'b1, 8'h55, w2, 1'b0, 8'h40, w1, w2);
      handshake(4'(i));
    end
    check("count_wrapped", 32'(pair_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
